dma_scheduler: RTL and testbench
================================

Name: dma_scheduler

Overview:
- Round-robin scheduler that shares the single DMA controller datapath between NUM_REQ requesters (weight loader, activation loader, result writeback, host).
- Each requester hands over one descriptor: source address, destination address and length in words.
- The block then sequences the DMA datapath one word at a time: start pulse, wait for done, advance both addresses by 4.
- It reports per-requester completion or abort. It sits between the TPU control unit's load/store agents and the DMA controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
LEN_W, 16, transfer length width in words
ADDR_STEP, 4, byte increment per word

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  descriptor valid per requester
req_ready  output  NUM_REQ  one-hot accept, combinational
req_src  input  NUM_REQ*ADDR_W  packed source addresses, requester i at slice i
req_dst  input  NUM_REQ*ADDR_W  packed destination addresses
req_len  input  NUM_REQ*LEN_W  packed lengths in words
cmp_valid  output  NUM_REQ  one-cycle completion pulse per requester
cmp_err  output  1  qualifies cmp_valid: 1 = transfer aborted
abort  input  1  synchronous abort of the current transfer
dma_start  output  1  one-cycle word-transfer request to the DMA controller
dma_src  output  ADDR_W  current source address
dma_dst  output  ADDR_W  current destination address
dma_done  input  1  DMA controller finished current word
busy  output  1  high in any state other than IDLE
grant_id  output  $clog2(NUM_REQ)  index of the owning requester

Behaviour:

Reset:
- rst asserted (asynchronous) gives:
  - state IDLE, rr pointer 0
  - req_ready, cmp_valid, cmp_err and dma_start all 0
  - dma_src, dma_dst, grant_id and busy all 0
- Reset mid-transfer drops the transfer silently: no cmp_valid.

States:
- IDLE:
  - Grant g = first requester with req_valid set, searching from the rr pointer upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 in the same cycle (combinational, state==IDLE only).
  - On the handshake: latch src, dst and len of g; set grant_id=g; set rr pointer=(g+1) mod NUM_REQ.
  - Next state is ISSUE if len!=0, otherwise DONE.
  - With no req_valid set, stay in IDLE; the pointer is unchanged.
- ISSUE:
  - dma_start=1 for exactly one cycle with dma_src/dma_dst equal to the current addresses.
  - Next state WAIT.
- WAIT:
  - Hold dma_src and dma_dst stable.
  - On dma_done: decrement remaining, add ADDR_STEP to both addresses (modulo 2^ADDR_W, wrap is silent).
  - If remaining was 1, go to DONE; otherwise go to ISSUE.
  - dma_done in any other state is ignored.
- DONE:
  - cmp_valid[grant_id]=1 for one cycle; cmp_err=0.
  - Next state IDLE.

Abort:
- Abort in ISSUE or WAIT goes to DONE with cmp_err=1.
- Abort wins over a simultaneous dma_done; that word is counted as not done.
- The dma_start pulse in ISSUE still fires in that cycle.
- Abort is ignored in IDLE and DONE.

Latency:
- Handshake at cycle T gives dma_start at T+1.
- The last dma_done at cycle D gives cmp_valid at D+1 and new grant eligibility at D+2.
- len=0 gives cmp_valid at T+1 with no dma_start.

Other rules:
- A requester must hold its descriptor stable while req_valid=1 and req_ready=0.
- Descriptor inputs are sampled only at the handshake.
- One transfer is in flight at a time; no pipelining across requesters.

Decomposition:
- Package dma_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE)
  - default ADDR_W/LEN_W/ADDR_STEP constants
  - a descriptor struct {src, dst, len}
- Natural sub-module: rr_arbiter
  - Combinational request vector plus pointer in, one-hot grant plus index out.
  - Reusable for the future memory-port arbiter.

Test Plan:
1. Single requester: req 0 with src=0x1000, dst=0x2000, len=3; dma_done 2 cycles after each start -> three dma_start pulses with src 0x1000/0x1004/0x1008 and dst 0x2000/0x2004/0x2008; cmp_valid[0] pulses once with cmp_err=0.
2. Fairness: all 4 requesters valid continuously, len=1 each, requests re-raised after completion -> grant order 0,1,2,3,0,1; no requester granted twice before the others.
3. Zero length: req 2 len=0 -> req_ready[2] at T, cmp_valid[2] at T+1, no dma_start, busy high for exactly 1 cycle.
4. Abort: req 1 with len=5, abort asserted together with the 2nd dma_done -> only 2 dma_start pulses total; cmp_valid[1] with cmp_err=1; next grant proceeds normally.
5. Address wrap: src=0xFFFFFFFC, len=2 -> second dma_src=0x00000000, no error.
6. Asynchronous reset asserted in WAIT mid-cycle -> all outputs 0 immediately, no cmp_valid; after release the rr pointer is 0 and req 3 alone is granted correctly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and default sizing for the DMA scheduler slice.
package dma_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_LEN_W     = 16;
  localparam int DEF_ADDR_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] src;
    logic [DEF_ADDR_W-1:0] dst;
    logic [DEF_LEN_W-1:0]  len;
  } desc_t;

endpackage

// File: rtl/dma_scheduler_if.sv
// Requester, completion and DMA-datapath signals of the scheduler.
interface dma_scheduler_if
  import dma_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W
) ();
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_src;
  logic [NUM_REQ*ADDR_W-1:0] req_dst;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        cmp_valid;
  logic                      cmp_err;
  logic                      abort;
  logic                      dma_start;
  logic [ADDR_W-1:0]         dma_src;
  logic [ADDR_W-1:0]         dma_dst;
  logic                      dma_done;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;

  modport slave (
    input  req_valid, req_src, req_dst, req_len, abort, dma_done,
    output req_ready, cmp_valid, cmp_err, dma_start, dma_src, dma_dst, busy, grant_id
  );

  modport master (
    output req_valid, req_src, req_dst, req_len, abort, dma_done,
    input  req_ready, cmp_valid, cmp_err, dma_start, dma_src, dma_dst, busy, grant_id
  );

endinterface

// File: rtl/dma_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [2*N-1:0]   dbl_s;
  logic [N-1:0]     rot_s;
  logic [IDX_W-1:0] off_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W:0]   wrap_s;

  // Rotate so bit k is requester (ptr+k) mod N, then pick the lowest set offset.
  always_comb begin
    dbl_s     = {req, req} >> ptr;
    rot_s     = dbl_s[N-1:0];
    off_s     = '0;
    grant_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      off_s     = rot_s[k] ? IDX_W'(k) : off_s;
      grant_any = grant_any | rot_s[k];
    end
    sum_s     = {1'b0, ptr} + {1'b0, off_s};
    wrap_s    = sum_s - (IDX_W+1)'(N);
    grant_idx = (sum_s >= (IDX_W+1)'(N)) ? wrap_s[IDX_W-1:0] : sum_s[IDX_W-1:0];
    grant     = grant_any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : {N{1'b0}};
  end

endmodule

// File: rtl/dma_scheduler.sv
// Round-robin owner of the DMA datapath: accepts one descriptor at a time and
// drives it word by word through start/done handshakes.
module dma_scheduler
  import dma_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int ADDR_STEP = DEF_ADDR_STEP
) (
  input  logic           clk,
  input  logic           rst,
  dma_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_e              state_r, state_s;
  logic [ADDR_W-1:0]   src_r, dst_r;
  logic [LEN_W-1:0]    rem_r;
  logic [IDX_W-1:0]    grant_r, ptr_r;
  logic                err_r;

  logic [NUM_REQ-1:0]  grant_oh_s;
  logic [IDX_W-1:0]    grant_idx_s, ptr_next_s;
  logic                grant_any_s, take_s;
  logic [ADDR_W-1:0]   sel_src_s, sel_dst_s;
  logic [LEN_W-1:0]    sel_len_s;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_r),
    .grant     (grant_oh_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign take_s     = (state_r == IDLE) && grant_any_s;
  assign ptr_next_s = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);

  // One-hot descriptor mux for the granted requester.
  always_comb begin
    sel_src_s = '0;
    sel_dst_s = '0;
    sel_len_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_src_s |= {ADDR_W{grant_oh_s[i]}} & bus.req_src[i*ADDR_W +: ADDR_W];
      sel_dst_s |= {ADDR_W{grant_oh_s[i]}} & bus.req_dst[i*ADDR_W +: ADDR_W];
      sel_len_s |= {LEN_W{grant_oh_s[i]}}  & bus.req_len[i*LEN_W +: LEN_W];
    end
  end

  // Next-state logic; abort takes priority over a coincident dma_done.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_s = (sel_len_s == '0) ? DONE : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_s = DONE;
        end else if (bus.dma_done) begin
          state_s = (rem_r == LEN_W'(1)) ? DONE : ISSUE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Descriptor latch, word counter, address stepping and abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_r   <= '0;
      dst_r   <= '0;
      rem_r   <= '0;
      grant_r <= '0;
      ptr_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            src_r   <= sel_src_s;
            dst_r   <= sel_dst_s;
            rem_r   <= sel_len_s;
            grant_r <= grant_idx_s;
            ptr_r   <= ptr_next_s;
            err_r   <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.abort) err_r <= 1'b1;
        end
        WAIT: begin
          if (bus.abort) begin
            err_r <= 1'b1;
          end else if (bus.dma_done) begin
            rem_r <= rem_r - LEN_W'(1);
            src_r <= src_r + STEP;
            dst_r <= dst_r + STEP;
          end
        end
        default: err_r <= err_r;
      endcase
    end
  end

  assign bus.req_ready = ((state_r == IDLE) && !rst) ? grant_oh_s : '0;
  assign bus.dma_start = (state_r == ISSUE);
  assign bus.dma_src   = src_r;
  assign bus.dma_dst   = dst_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.grant_id  = grant_r;
  assign bus.cmp_err   = (state_r == DONE) && err_r;
  assign bus.cmp_valid = (state_r == DONE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r) : '0;

endmodule

// File: tb/tb_dma_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-timeline reference model of the scheduler's rules.
module tb_dma_scheduler;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_scheduler_if bus ();

  dma_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  desc_t      d [4];
  logic [3:0] pend = 4'b0;
  bit         reraise = 1'b0;
  bit         abort_v = 1'b0;
  bit         spur_en = 1'b0;
  int         abort_word = 0;
  int         dly_min = 1, dly_max = 3;
  int         done_due = -1;

  // reference model
  bit          m_busy, m_wait, m_err;
  int          m_owner, m_rr, m_len, m_rem, m_start_due, m_cmp_due;
  logic [31:0] m_cur_src, m_cur_dst;

  int          grant_log[$];
  int          cmp_log[$];
  logic [31:0] src_log[$];
  logic [31:0] dst_log[$];
  int          n_starts, n_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_err = 0; m_owner = 0; m_rr = 0;
    m_len = 0; m_rem = 0; m_start_due = -1; m_cmp_due = -1; done_due = -1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); cmp_log.delete(); src_log.delete(); dst_log.delete();
    n_starts = 0; n_busy = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 4'b0);
    chk({tag, "_cmp_valid"}, bus.cmp_valid, 4'b0);
    chk({tag, "_cmp_err"},   bus.cmp_err,   1'b0);
    chk({tag, "_dma_start"}, bus.dma_start, 1'b0);
    chk({tag, "_dma_src"},   bus.dma_src,   32'h0);
    chk({tag, "_dma_dst"},   bus.dma_dst,   32'h0);
    chk({tag, "_grant_id"},  bus.grant_id,  2'd0);
    chk({tag, "_busy"},      bus.busy,      1'b0);
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic step();
    int g;
    logic [3:0] exp_rdy, exp_cmp;
    bit exp_start, a, dn;
    for (int i = 0; i < 4; i++) begin
      bus.req_src[i*32 +: 32] = d[i].src;
      bus.req_dst[i*32 +: 32] = d[i].dst;
      bus.req_len[i*16 +: 16] = d[i].len;
    end
    bus.req_valid = pend;
    a  = abort_v || (abort_word != 0 && cyc == done_due && (m_len - m_rem) == abort_word - 1);
    dn = (cyc == done_due) || (spur_en && !m_wait && $urandom_range(0, 5) == 0);
    bus.abort    = a;
    bus.dma_done = dn;
    #1;
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      end
    end
    exp_rdy   = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    exp_start = m_busy && (cyc == m_start_due);
    exp_cmp   = (m_busy && cyc == m_cmp_due) ? (4'b0001 << m_owner) : 4'b0000;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("busy",      bus.busy,      m_busy);
    chk("dma_start", bus.dma_start, exp_start);
    chk("cmp_valid", bus.cmp_valid, exp_cmp);
    if (exp_cmp != 4'b0) chk("cmp_err", bus.cmp_err, m_err);
    if (exp_start || m_wait) begin
      chk("dma_src", bus.dma_src, m_cur_src);
      chk("dma_dst", bus.dma_dst, m_cur_dst);
    end
    if (m_busy) chk("grant_id", bus.grant_id, m_owner);
    if (bus.dma_start === 1'b1) begin
      n_starts++;
      src_log.push_back(bus.dma_src);
      dst_log.push_back(bus.dma_dst);
    end
    if (bus.busy === 1'b1) n_busy++;
    for (int i = 0; i < 4; i++) begin
      if (bus.cmp_valid[i] === 1'b1) cmp_log.push_back(i + (bus.cmp_err ? 16 : 0));
      if (bus.req_ready[i] === 1'b1 && pend[i]) grant_log.push_back(i);
    end
    if (!m_busy) begin
      if (g >= 0) begin
        pend[g] = 1'b0;
        m_busy = 1; m_owner = g; m_rr = (g + 1) % 4; m_err = 0; m_wait = 0;
        m_cur_src = d[g].src; m_cur_dst = d[g].dst;
        m_len = int'(d[g].len); m_rem = m_len;
        if (m_len == 0) begin
          m_cmp_due = cyc + 1; m_start_due = -1;
        end else begin
          m_start_due = cyc + 1; m_cmp_due = -1;
        end
      end
    end else if (cyc == m_cmp_due) begin
      m_busy = 0;
      if (reraise) pend[m_owner] = 1'b1;
    end else if (cyc == m_start_due) begin
      if (a) begin
        m_err = 1; m_cmp_due = cyc + 1; m_start_due = -1;
      end else begin
        m_wait = 1; done_due = cyc + $urandom_range(dly_min, dly_max);
      end
    end else if (m_wait) begin
      if (a) begin
        m_err = 1; m_wait = 0; m_cmp_due = cyc + 1; done_due = -1;
      end else if (dn) begin
        m_wait = 0; m_rem--;
        m_cur_src = m_cur_src + 32'd4;
        m_cur_dst = m_cur_dst + 32'd4;
        if (m_rem == 0) m_cmp_due = cyc + 1;
        else            m_start_due = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int n = 0; n < bound && (m_busy || pend != 4'b0); n++) step();
    chk({tag, "_drain_timeout"}, (m_busy || pend != 4'b0), 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic post(input int r, input logic [31:0] s, input logic [31:0] t, input logic [15:0] l);
    d[r].src = s; d[r].dst = t; d[r].len = l;
    pend[r] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) d[i] = '0;
    bus.req_valid = '0; bus.req_src = '0; bus.req_dst = '0; bus.req_len = '0;
    bus.abort = 1'b0; bus.dma_done = 1'b0;
    model_reset();
    @(negedge clk);
    reset_dut();

    // 1: single requester, three words, done two cycles after each start
    clear_logs(); dly_min = 2; dly_max = 2;
    post(0, 32'h1000, 32'h2000, 16'd3);
    drain("t1", 40);
    chk("t1_starts", n_starts, 3);
    chk("t1_src0", src_log[0], 32'h1000);
    chk("t1_src1", src_log[1], 32'h1004);
    chk("t1_src2", src_log[2], 32'h1008);
    chk("t1_dst2", dst_log[2], 32'h2008);
    chk("t1_cmp_n", cmp_log.size(), 1);
    chk("t1_cmp", cmp_log[0], 0);

    // 2: fairness with continuously re-raised len=1 requests
    reset_dut();
    clear_logs(); dly_min = 1; dly_max = 3; reraise = 1'b1;
    for (int i = 0; i < 4; i++) post(i, 32'h100 * i, 32'h8000 + 32'h100 * i, 16'd1);
    for (int n = 0; n < 100 && grant_log.size() < 6; n++) step();
    reraise = 1'b0;
    chk("t2_grants_n", grant_log.size() >= 6, 1'b1);
    chk("t2_g0", grant_log[0], 0);
    chk("t2_g1", grant_log[1], 1);
    chk("t2_g2", grant_log[2], 2);
    chk("t2_g3", grant_log[3], 3);
    chk("t2_g4", grant_log[4], 0);
    chk("t2_g5", grant_log[5], 1);
    drain("t2", 80);

    // 3: zero-length descriptor
    clear_logs();
    post(2, 32'hA000, 32'hB000, 16'd0);
    for (int n = 0; n < 6; n++) step();
    chk("t3_starts", n_starts, 0);
    chk("t3_busy_cycles", n_busy, 1);
    chk("t3_cmp", cmp_log.size() == 1 ? cmp_log[0] : -1, 2);

    // 4: abort together with the second dma_done, then a normal transfer
    clear_logs(); abort_word = 2;
    post(1, 32'h3000, 32'h4000, 16'd5);
    drain("t4", 40);
    abort_word = 0;
    chk("t4_starts", n_starts, 2);
    chk("t4_cmp", cmp_log.size() == 1 ? cmp_log[0] : -1, 1 + 16);
    clear_logs();
    post(0, 32'h5000, 32'h6000, 16'd1);
    drain("t4b", 20);
    chk("t4b_cmp", cmp_log.size() == 1 ? cmp_log[0] : -1, 0);

    // 5: source address wraps silently
    clear_logs();
    post(3, 32'hFFFF_FFFC, 32'h7000, 16'd2);
    drain("t5", 30);
    chk("t5_src1", src_log.size() == 2 ? src_log[1] : 32'hDEAD, 32'h0);
    chk("t5_cmp", cmp_log.size() == 1 ? cmp_log[0] : -1, 3);

    // 6: asynchronous reset in WAIT, then req 3 alone
    clear_logs(); dly_min = 3; dly_max = 3;
    post(2, 32'hC000, 32'hD000, 16'd3);
    for (int n = 0; n < 20 && !m_wait; n++) step();
    chk("t6_reached_wait", m_wait, 1'b1);
    post(3, 32'hE000, 32'hF000, 16'd1);
    bus.req_valid = pend;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_logs();
    drain("t6", 20);
    chk("t6_grant", grant_log.size() == 1 ? grant_log[0] : -1, 3);
    chk("t6_cmp", cmp_log.size() == 1 ? cmp_log[0] : -1, 3);

    // random traffic: arrivals, lengths, wrap-prone addresses, aborts, stray dones
    dly_min = 1; dly_max = 3; spur_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          post(i, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4) : $urandom,
               $urandom, 16'($urandom_range(0, 4)));
        end
      end
      abort_v = ($urandom_range(0, 29) == 0);
      step();
    end
    abort_v = 1'b0;
    drain("rand", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
